// File: rtl/alu_16.sv
// alu_16: bit-serial 16-bit ALU. It processes one operand bit per clock, LSB first,
// using a single 1-bit adder/logic slice and a carry flip-flop.
// Partial results are visible on out while the operation runs.
//
// state  | meaning
// IDLE   | after reset; out/count hold until the first on pulse
// LOAD   | operands and op captured while on=1; out/count cleared
// RUN    | one result bit per edge at index count
// DONE   | final 17-bit result held, count=15
module alu_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        on,
  input  logic [15:0] ina,
  input  logic [15:0] inb,
  input  logic [2:0]  op,
  output logic [16:0] out,
  output logic [3:0]  count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  logic [1:0]  r_rst_sync;
  logic [1:0]  r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [2:0]  r_op;
  logic [16:0] r_out;
  logic [3:0]  r_count;
  logic        r_carry;

  logic        w_run_en;
  logic        w_a;
  logic        w_b_raw;
  logic        w_b;
  logic        w_arith;
  logic        w_bit;
  logic        w_carry_nxt;
  logic [4:0]  w_idx;

  // Reset release is synchronized so the release edge itself changes no state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run_en = r_rst_sync[1];

  assign w_a      = r_a[r_count];
  assign w_b_raw  = r_b[r_count];
  // SUB is A + ~B + 1; the +1 comes from presetting carry in LOAD
  assign w_b      = (r_op == OP_SUB) ? ~w_b_raw : w_b_raw;
  assign w_arith  = (r_op == OP_ADD) || (r_op == OP_SUB);
  assign w_idx    = {1'b0, r_count};

  assign w_carry_nxt = (w_a & w_b) | (w_a & r_carry) | (w_b & r_carry);

  // One-bit slice: selects the result bit for the current index
  always_comb begin
    w_bit = 1'b0;
    case (r_op)
      OP_ADD,
      OP_SUB:  w_bit = w_a ^ w_b ^ r_carry;
      OP_AND:  w_bit = w_a & w_b_raw;
      OP_OR:   w_bit = w_a | w_b_raw;
      OP_XOR:  w_bit = w_a ^ w_b_raw;
      OP_NAND: w_bit = ~(w_a & w_b_raw);
      OP_NOR:  w_bit = ~(w_a | w_b_raw);
      OP_XNOR: w_bit = ~(w_a ^ w_b_raw);
      default: w_bit = 1'b0;
    endcase
  end

  // Sequencer: on=1 restarts from any state; otherwise LOAD -> RUN -> DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_op    <= 3'b000;
      r_out   <= 17'h00000;
      r_count <= 4'h0;
      r_carry <= 1'b0;
    end else if (w_run_en) begin
      if (on) begin
        r_state <= S_LOAD;
        r_a     <= ina;
        r_b     <= inb;
        r_op    <= op;
        r_out   <= 17'h00000;
        r_count <= 4'h0;
        r_carry <= (op == OP_SUB);
      end else begin
        case (r_state)
          S_LOAD: begin
            r_state <= S_RUN;
            r_count <= 4'h0;
          end
          S_RUN: begin
            r_out[w_idx] <= w_bit;
            r_carry      <= w_carry_nxt;
            if (r_count == 4'd15) begin
              r_out[16] <= w_arith ? w_carry_nxt : 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_count <= r_count + 4'd1;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign out   = r_out;
  assign count = r_count;

endmodule

// File: tb/tb_alu_16.sv
// Testbench for alu_16: scenario tasks with a result scoreboard queue.
module tb_alu_16;

  logic        clk;
  logic        rst_n;
  logic        on;
  logic [15:0] ina;
  logic [15:0] inb;
  logic [2:0]  op;
  logic [16:0] out;
  logic [3:0]  count;

  int n_checks;
  int n_pass;
  logic [16:0] sb_q[$];

  alu_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .on    (on),
    .ina   (ina),
    .inb   (inb),
    .op    (op),
    .out   (out),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result computed with plain word arithmetic
  function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] r;
    case (o)
      3'b000:  r = {1'b0, a} + {1'b0, b};
      3'b001:  r = {1'b0, a} + {1'b0, ~b} + 17'd1;
      3'b010:  r = {1'b0, a & b};
      3'b011:  r = {1'b0, a | b};
      3'b100:  r = {1'b0, a ^ b};
      3'b101:  r = {1'b0, ~(a & b)};
      3'b110:  r = {1'b0, ~(a | b)};
      default: r = {1'b0, ~(a ^ b)};
    endcase
    return r;
  endfunction

  // Entered just after a negedge; leaves after the LOAD edge with on=0 driven
  task automatic start_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    on  = 1'b1;
    op  = o;
    ina = a;
    inb = b;
    @(negedge clk);
    on  = 1'b0;
  endtask

  // Runs the 17 latency edges with scrambled inputs, then checks against the scoreboard
  task automatic finish_op(input string name);
    logic [16:0] exp;
    repeat (17) begin
      @(negedge clk);
      ina = 16'($urandom);
      inb = 16'($urandom);
      op  = 3'($urandom);
    end
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, out=%h", name, out);
      exp = 17'h0;
    end else begin
      exp = sb_q.pop_front();
      if (out !== exp) $display("FAIL %s result: got %h expected %h", name, out, exp);
      else n_pass++;
    end
    n_checks++;
    if (count !== 4'd15) $display("FAIL %s count: got %0d expected 15", name, count);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    on    = 1'b0;
    ina   = 16'h0;
    inb   = 16'h0;
    op    = 3'b000;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out !== 17'h0) $display("FAIL reset_out: got %h expected 00000", out);
    else n_pass++;
    n_checks++;
    if (count !== 4'h0) $display("FAIL reset_count: got %0d expected 0", count);
    else n_pass++;
    rst_n = 1'b1;
    ina   = 16'hFFFF;
    op    = 3'b011;
    repeat (4) @(negedge clk);
    n_checks++;
    if (out !== 17'h0 || count !== 4'h0)
      $display("FAIL idle_hold: got out=%h count=%0d expected 00000/0", out, count);
    else n_pass++;
  endtask

  task automatic test_spec_vectors;
    start_op(3'b011, 16'h7003, 16'hC003);
    sb_q.push_back(17'h0F003);
    finish_op("or_vec");
    repeat (32) @(negedge clk);
    n_checks++;
    if (out !== 17'h0F003 || count !== 4'd15)
      $display("FAIL or_hold: got out=%h count=%0d expected 0f003/15", out, count);
    else n_pass++;
    start_op(3'b000, 16'h7003, 16'hC003);
    sb_q.push_back(17'h13006);
    finish_op("add_vec");
    start_op(3'b001, 16'h7003, 16'hC003);
    sb_q.push_back(17'h0B000);
    finish_op("sub_vec");
    start_op(3'b010, 16'h7003, 16'hC003);
    sb_q.push_back(17'h04003);
    finish_op("and_vec");
    start_op(3'b100, 16'h7003, 16'hC003);
    sb_q.push_back(17'h0B000);
    finish_op("xor_vec");
  endtask

  // Count steps 0..15 and partial LSB-first results are visible during RUN
  task automatic test_add_steps;
    logic [16:0] exp;
    logic [16:0] mask;
    exp = model(3'b000, 16'hBEEF, 16'h4321);
    start_op(3'b000, 16'hBEEF, 16'h4321);
    sb_q.push_back(exp);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      mask = (17'h1 << (k - 1)) - 17'h1;
      n_checks++;
      if (count !== 4'(k - 1)) $display("FAIL add_step_count k=%0d: got %0d expected %0d", k, count, k - 1);
      else n_pass++;
      n_checks++;
      if (out !== (exp & mask)) $display("FAIL add_partial k=%0d: got %h expected %h", k, out, exp & mask);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (out !== sb_q.pop_front()) $display("FAIL add_steps_final: got %h expected %h", out, exp);
    else n_pass++;
  endtask

  task automatic test_abort;
    start_op(3'b000, 16'h7003, 16'hC003);
    repeat (8) @(negedge clk);
    n_checks++;
    if (count !== 4'd7) $display("FAIL abort_pre_count: got %0d expected 7", count);
    else n_pass++;
    start_op(3'b001, 16'h1234, 16'h0235);
    n_checks++;
    if (out !== 17'h0 || count !== 4'h0)
      $display("FAIL abort_clear: got out=%h count=%0d expected 00000/0", out, count);
    else n_pass++;
    sb_q.push_back(model(3'b001, 16'h1234, 16'h0235));
    finish_op("abort_new");
  endtask

  // LOAD recaptures every edge while on stays high; the last capture wins
  task automatic test_load_persist;
    on  = 1'b1;
    op  = 3'b000;
    ina = 16'h1111;
    inb = 16'h2222;
    @(negedge clk);
    op  = 3'b110;
    ina = 16'h0F0F;
    inb = 16'h00FF;
    @(negedge clk);
    on  = 1'b0;
    sb_q.push_back(model(3'b110, 16'h0F0F, 16'h00FF));
    finish_op("load_persist");
  endtask

  task automatic test_reset_mid_run;
    start_op(3'b000, 16'hFFFF, 16'h0001);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out !== 17'h0 || count !== 4'h0)
      $display("FAIL async_reset: got out=%h count=%0d expected 00000/0", out, count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (out !== 17'h0 || count !== 4'h0)
      $display("FAIL post_reset_idle: got out=%h count=%0d expected 00000/0", out, count);
    else n_pass++;
    start_op(3'b000, 16'hFFFF, 16'h0001);
    sb_q.push_back(17'h10000);
    finish_op("post_reset_add");
  endtask

  task automatic test_back_to_back;
    logic [2:0]  o;
    logic [15:0] a;
    logic [15:0] b;
    for (int i = 0; i < 12; i++) begin
      o = (i < 8) ? 3'(i) : 3'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      start_op(o, a, b);
      sb_q.push_back(model(o, a, b));
      finish_op("b2b");
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_spec_vectors();
    test_add_steps();
    test_abort();
    test_load_persist();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_16.md
ALU_16 -- requirements
Module: alu_16

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  rising-edge clock; free-running, may come from an on-chip oscillator.
- rst_n  in  1  asynchronous active-low reset.
- on  in  1  start/load strobe, level-sampled on clk.
- ina  in  16  operand A, unsigned.
- inb  in  16  operand B, unsigned.
- op  in  3  operation select.
- out  out  17  result; out[15:0] = data, out[16] = carry flag.
- count  out  4  current bit index of the serial computation.
REQ-003 No parameters SHALL exist; widths are fixed at 16/17/4/3.

Function
REQ-004 The block SHALL be a bit-serial ALU processing one operand bit per clk cycle, LSB first, using one 1-bit adder/logic slice and a carry flip-flop.
REQ-005 The state machine SHALL have states IDLE, LOAD, RUN and DONE.
REQ-006 In any state, on=1 sampled at a rising edge SHALL enter LOAD, which:
- captures ina, inb and op into internal registers;
- clears out to 0 and count to 0;
- presets carry to 1 for SUB and 0 otherwise.
REQ-007 LOAD SHALL persist while on=1, recapturing inputs every edge.
REQ-008 The first edge with on=0 in LOAD SHALL enter RUN with count=0; no bit is processed on that edge.
REQ-009 In RUN, each rising edge SHALL:
- compute the result bit for index count from A[count], B[count] and carry;
- write that bit to out[count] and update carry;
- increment count, if count<15.
REQ-010 At count=15 in RUN, the edge SHALL:
- write out[15];
- write the final carry (arithmetic ops) or 0 (logic ops) to out[16];
- enter DONE.
REQ-011 In DONE, out SHALL hold the final result and count SHALL hold 15 until on=1 or reset.
REQ-012 In IDLE, out and count SHALL hold their values; IDLE is reached only from reset.
REQ-013 Latency: the final 17-bit result SHALL be valid after the 17th rising edge counted from, and including, the first edge sampling on=0 in LOAD.
REQ-014 During RUN, out[15:count] not yet computed SHALL read 0; partial results are visible.
REQ-015 op encoding SHALL be:
- 000 ADD: A+B, out[16]=carry-out.
- 001 SUB: A+~B+1, out[16]=carry-out, where 1 means no borrow.
- 010 AND.
- 011 OR.
- 100 XOR.
- 101 NAND.
- 110 NOR.
- 111 XNOR.
REQ-016 For logic ops, out[16] SHALL be 0.
REQ-017 Arithmetic SHALL be modulo 2^16 in out[15:0], with no overflow flag.
REQ-018 Changes to ina/inb/op outside LOAD SHALL have no effect on an operation in progress.
REQ-019 on=1 during RUN SHALL abort the operation and restart via LOAD (REQ-006).
REQ-020 The design SHALL be synchronous to clk apart from rst_n; there are no combinational paths from inputs to outputs.

Reset
REQ-021 rst_n=0 SHALL immediately force the following regardless of clk:
- state=IDLE;
- out=17'h00000;
- count=4'h0;
- carry=0;
- operand registers cleared.
REQ-022 Reset asserted mid-RUN SHALL discard the operation; after release the block SHALL stay in IDLE until on=1 is sampled.
REQ-023 Reset deassertion SHALL be synchronized to clk internally so that no state change occurs on the release edge.

Verification
REQ-024 op=011 (OR), A=16'h7003, B=16'hC003, on pulsed high for 1+ cycles -> out=17'h0F003 and count=15 after 17 edges; both hold for 32+ further cycles.
REQ-025 op=000 (ADD), same operands -> out=17'h13006; count steps 0..15 during RUN.
REQ-026 op=001 (SUB), same operands -> out=17'h0B000 (carry=0, borrow).
REQ-027 op=010 (AND) -> out=17'h04003; op=100 (XOR) -> out=17'h0B000.
REQ-028 on re-asserted at count=7 of an ADD -> out and count clear to 0; the new operation completes correctly with fresh operands.
REQ-029 rst_n pulsed low mid-RUN without a clock edge -> out=0, count=0 immediately; the block stays idle until the next on pulse.
